// File: rtl/control_unit.sv
// Purpose: combinational instruction decoder with a sticky halted state bit.
// Latency: outputs follow instr in the same cycle; halted updates on the next rising clk edge.
// Backpressure: none; the block decodes whatever instruction is presented each cycle.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic [1:0]  WBSelect,
  output logic        NZP_we,
  output logic        Branch,
  output logic [1:0]  BranchCond,
  output logic        Jump,
  output logic        Call,
  output logic        Ret,
  output logic        Halt,
  output logic [3:0]  ALUOp
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b0100;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] BC_EQ = 2'b01;
  localparam logic [1:0] BC_LT = 2'b10;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] opcode;
  logic       halted;

  // Operand fields are decoded elsewhere; they are deliberately ignored here.
  logic       unused_operand_bits;

  assign opcode              = instr[15:12];
  assign halted              = (state == ST_HALTED);
  assign unused_operand_bits = ^instr[11:0];

  // State register: reset always wins over a coincident HALT opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a HALT opcode parks the block until reset; nothing else leaves HALTED.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (opcode == 4'hF) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Output decode: reset forces everything low, halted exposes only Halt, otherwise opcode map.
  always_comb begin
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    WBSelect   = WB_ALU;
    NZP_we     = 1'b0;
    Branch     = 1'b0;
    BranchCond = 2'b00;
    Jump       = 1'b0;
    Call       = 1'b0;
    Ret        = 1'b0;
    Halt       = 1'b0;
    ALUOp      = ALU_ADD;
    if (rst) begin
      // all outputs stay at their zero defaults
    end else if (halted) begin
      Halt = 1'b1;
    end else begin
      case (opcode)
        4'h0: begin RegWrite = 1'b1; NZP_we = 1'b1; ALUOp = ALU_ADD; end
        4'h1: begin RegWrite = 1'b1; NZP_we = 1'b1; ALUOp = ALU_SUB; end
        4'h2: begin RegWrite = 1'b1; NZP_we = 1'b1; ALUOp = ALU_AND; end
        4'h3: begin RegWrite = 1'b1; NZP_we = 1'b1; ALUOp = ALU_OR;  end
        4'h4: begin NZP_we = 1'b1; ALUOp = ALU_SUB; end
        4'h5: begin RegWrite = 1'b1; ALUSrc = 1'b1; NZP_we = 1'b1; ALUOp = ALU_ADD; end
        4'h6: begin RegWrite = 1'b1; ALUSrc = 1'b1; NZP_we = 1'b1; ALUOp = ALU_OR;  end
        4'h7: begin RegWrite = 1'b1; ALUSrc = 1'b1; ALUOp = ALU_PASS; end
        4'h8: begin
          RegWrite = 1'b1;
          ALUSrc   = 1'b1;
          MemToReg = 1'b1;
          WBSelect = WB_MEM;
          ALUOp    = ALU_ADD;
        end
        4'h9: begin ALUSrc = 1'b1; MemWrite = 1'b1; ALUOp = ALU_ADD; end
        4'hA: begin Branch = 1'b1; BranchCond = BC_EQ; ALUOp = ALU_SUB; end
        4'hB: begin Branch = 1'b1; BranchCond = BC_LT; ALUOp = ALU_SUB; end
        4'hC: begin Jump = 1'b1; end
        4'hD: begin Jump = 1'b1; Call = 1'b1; RegWrite = 1'b1; WBSelect = WB_LINK; end
        4'hE: begin Ret = 1'b1; end
        4'hF: begin Halt = 1'b1; end
        default: begin end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Purpose: directed self-checking bench for control_unit decode, halt and reset behaviour.
// Latency: decode is checked 1 time unit after instr changes; halted is checked after clock edges.
// Backpressure: not applicable.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        RegWrite;
  logic        ALUSrc;
  logic        MemWrite;
  logic        MemToReg;
  logic [1:0]  WBSelect;
  logic        NZP_we;
  logic        Branch;
  logic [1:0]  BranchCond;
  logic        Jump;
  logic        Call;
  logic        Ret;
  logic        Halt;
  logic [3:0]  ALUOp;

  int checks;
  int errors;

  // Observed outputs packed as {RegWrite,ALUSrc,MemWrite,MemToReg,WBSelect,NZP_we,
  // Branch,BranchCond,Jump,Call,Ret,Halt,ALUOp}.
  logic [17:0] obs;
  logic [17:0] exp_tab [16];

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .WBSelect   (WBSelect),
    .NZP_we     (NZP_we),
    .Branch     (Branch),
    .BranchCond (BranchCond),
    .Jump       (Jump),
    .Call       (Call),
    .Ret        (Ret),
    .Halt       (Halt),
    .ALUOp      (ALUOp)
  );

  assign obs = {RegWrite, ALUSrc, MemWrite, MemToReg, WBSelect, NZP_we,
                Branch, BranchCond, Jump, Call, Ret, Halt, ALUOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ev(input logic rw, input logic src, input logic mw,
                                     input logic mr, input logic [1:0] wb, input logic nzp,
                                     input logic br, input logic [1:0] bc, input logic j,
                                     input logic c, input logic r, input logic h,
                                     input logic [3:0] alu);
    return {rw, src, mw, mr, wb, nzp, br, bc, j, c, r, h, alu};
  endfunction

  task automatic build_table();
    //                rw src mw mr wb     nzp br bc     j  c  r  h  alu
    exp_tab[0]  = ev(1, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000);
    exp_tab[1]  = ev(1, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0001);
    exp_tab[2]  = ev(1, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0010);
    exp_tab[3]  = ev(1, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0011);
    exp_tab[4]  = ev(0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0001);
    exp_tab[5]  = ev(1, 1, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0000);
    exp_tab[6]  = ev(1, 1, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0, 4'b0011);
    exp_tab[7]  = ev(1, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0100);
    exp_tab[8]  = ev(1, 1, 0, 1, 2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000);
    exp_tab[9]  = ev(0, 1, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0000);
    exp_tab[10] = ev(0, 0, 0, 0, 2'b00, 0, 1, 2'b01, 0, 0, 0, 0, 4'b0001);
    exp_tab[11] = ev(0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 0, 0, 0, 0, 4'b0001);
    exp_tab[12] = ev(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 1, 0, 0, 0, 4'b0000);
    exp_tab[13] = ev(1, 0, 0, 0, 2'b10, 0, 0, 2'b00, 1, 1, 0, 0, 4'b0000);
    exp_tab[14] = ev(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 4'b0000);
    exp_tab[15] = ev(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000);
  endtask

  // Reset forces all outputs low even with a HALT or ADD opcode present.
  task automatic test_reset();
    logic [17:0] halt_only;
    halt_only = ev(0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000);
    @(negedge clk);
    rst = 1'b1; instr = 16'hF000;
    #1;
    checks++;
    if (obs !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs_f000: got %b expected %b", obs, 18'd0);
    end
    @(negedge clk);
    instr = 16'h0000;
    #1;
    checks++;
    if (obs !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs_0000: got %b expected %b", obs, 18'd0);
    end
    // Release with ADD: decode resumes in the same cycle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== exp_tab[0] || Halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_add: got %b expected %b", obs, exp_tab[0]);
    end
    // Make sure the F000 seen during reset did not leave the block halted.
    @(negedge clk);
    #1;
    checks++;
    if (obs === halt_only) begin
      errors++;
      $display("FAIL reset_no_halt: got %b expected %b", obs, exp_tab[0]);
    end
  endtask

  // Opcodes 0..E, one per cycle, with operand bits zero.
  task automatic test_decode();
    for (int op = 0; op < 15; op++) begin
      @(negedge clk);
      instr = {op[3:0], 12'h000};
      #1;
      checks++;
      if (obs !== exp_tab[op]) begin
        errors++;
        $display("FAIL decode_op%0h: got %b expected %b", op, obs, exp_tab[op]);
      end
    end
  endtask

  // Operand bits must not change the decode.
  task automatic test_ignore_low();
    logic [15:0] vec [4];
    logic [17:0] want [4];
    vec[0] = 16'hA5F3; want[0] = exp_tab[10];
    vec[1] = 16'h0FFF; want[1] = exp_tab[0];
    vec[2] = 16'h8ABC; want[2] = exp_tab[8];
    vec[3] = 16'hD123; want[3] = exp_tab[13];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr = vec[i];
      #1;
      checks++;
      if (obs !== want[i]) begin
        errors++;
        $display("FAIL ignore_low_%h: got %b expected %b", vec[i], obs, want[i]);
      end
    end
  endtask

  // HALT is visible combinationally, then sticks across later instructions.
  task automatic test_halt();
    logic [15:0] after [4];
    after[0] = 16'h0000;
    after[1] = 16'h8000;
    after[2] = 16'hD000;
    after[3] = 16'hA000;
    @(negedge clk);
    instr = 16'hF000;
    #1;
    checks++;
    if (obs !== exp_tab[15]) begin
      errors++;
      $display("FAIL halt_comb: got %b expected %b", obs, exp_tab[15]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr = after[i];
      #1;
      checks++;
      if (obs !== exp_tab[15]) begin
        errors++;
        $display("FAIL halt_sticky_%h: got %b expected %b", after[i], obs, exp_tab[15]);
      end
    end
  endtask

  // A single reset edge clears halted; ADD decodes normally afterwards.
  task automatic test_reset_clears_halt();
    @(negedge clk);
    rst = 1'b1; instr = 16'h0000;
    #1;
    checks++;
    if (obs !== 18'd0) begin
      errors++;
      $display("FAIL reset_while_halted: got %b expected %b", obs, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== exp_tab[0] || RegWrite !== 1'b1 || Halt !== 1'b0) begin
      errors++;
      $display("FAIL unhalt_add: got %b expected %b", obs, exp_tab[0]);
    end
  endtask

  // Reset coinciding with a HALT opcode at the edge: reset wins.
  task automatic test_reset_vs_halt();
    @(negedge clk);
    rst = 1'b1; instr = 16'hF000;
    #1;
    checks++;
    if (obs !== 18'd0) begin
      errors++;
      $display("FAIL rst_with_halt_comb: got %b expected %b", obs, 18'd0);
    end
    @(negedge clk);
    rst = 1'b0; instr = 16'h0000;
    #1;
    checks++;
    if (obs !== exp_tab[0]) begin
      errors++;
      $display("FAIL rst_beats_halt: got %b expected %b", obs, exp_tab[0]);
    end
    @(negedge clk);
    instr = 16'h1234;
    #1;
    checks++;
    if (obs !== exp_tab[1]) begin
      errors++;
      $display("FAIL rst_beats_halt_next: got %b expected %b", obs, exp_tab[1]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    instr  = 16'h0000;
    build_table();
    test_reset();
    test_decode();
    test_ignore_low();
    test_halt();
    test_reset_clears_halt();
    test_reset_vs_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
